phase1_control_fsm: RTL

- Multi-cycle control sequencer for the accumulator processor front end.
- Drives the PC mux select and the PC, IR and accumulator write enables.
- Sequences each instruction through fetch, decode, execute and memory/writeback states from the 4-bit opcode in IR[15:12].
- Sits between the instruction register and the Phase1 PC/IM datapath plus the later accumulator/data-memory stages.

---
 rtl/phase1_control_fsm_if.sv | 72 +++++++
 rtl/phase1_control_fsm.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/phase1_control_fsm_if.sv
// Control bundle between the Phase1 sequencer and the
// IR / PC / accumulator / data-memory datapath.
//
// Signals:
//   Opcode    IR[15:12] of the latched instruction
//   Zero      accumulator == 0 flag
//   MemReady  data-memory access complete this cycle
//   PCSelect  PC mux select (0 PC+1, 1 branch, 2 jr, 3 jump)
//   PCWrite, IRWrite, AccWrite, AccSrcMem, MemRead,
//   MemWrite, LinkWrite  datapath strobes
//   Halted, BusErr, State, InstrCount  status / debug
//
// Modports:
//   master  the sequencer (drives controls, reads flags)
//   slave   the datapath side
interface phase1_control_fsm_if #(
  parameter int COUNT_WIDTH = 16
);

  logic [3:0]             Opcode;
  logic                   Zero;
  logic                   MemReady;
  logic [1:0]             PCSelect;
  logic                   PCWrite;
  logic                   IRWrite;
  logic                   AccWrite;
  logic                   AccSrcMem;
  logic                   MemRead;
  logic                   MemWrite;
  logic                   LinkWrite;
  logic                   Halted;
  logic                   BusErr;
  logic [2:0]             State;
  logic [COUNT_WIDTH-1:0] InstrCount;

  modport master (
    input  Opcode,
    input  Zero,
    input  MemReady,
    output PCSelect,
    output PCWrite,
    output IRWrite,
    output AccWrite,
    output AccSrcMem,
    output MemRead,
    output MemWrite,
    output LinkWrite,
    output Halted,
    output BusErr,
    output State,
    output InstrCount
  );

  modport slave (
    output Opcode,
    output Zero,
    output MemReady,
    input  PCSelect,
    input  PCWrite,
    input  IRWrite,
    input  AccWrite,
    input  AccSrcMem,
    input  MemRead,
    input  MemWrite,
    input  LinkWrite,
    input  Halted,
    input  BusErr,
    input  State,
    input  InstrCount
  );

endinterface

// File: rtl/phase1_control_fsm.sv
// Phase1 multi-cycle control sequencer for the accumulator core.
// Walks each instruction through FETCH/DECODE/EXEC/MEM/WB/JUMP.
//
// Ports:
//   CLK      rising-edge clock
//   Reset_n  synchronous active-low reset
//   Step     (STEP_MODE_EN only) single-step gate for FETCH
//   bus      phase1_control_fsm_if.master control bundle
//
// Optional feature: define STEP_MODE_EN to add the Step input;
// the FSM then idles in FETCH until Step is sampled high.
module phase1_control_fsm #(
  parameter int COUNT_WIDTH = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic CLK,
  input  logic Reset_n,
`ifdef STEP_MODE_EN
  input  logic Step,
`endif
  phase1_control_fsm_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_JUMP   = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [3:0] OP_ALU   = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_BEQZ  = 4'h3;
  localparam logic [3:0] OP_BNEZ  = 4'h4;
  localparam logic [3:0] OP_J     = 4'h5;
  localparam logic [3:0] OP_JR    = 4'h6;
  localparam logic [3:0] OP_JAL   = 4'h7;
  localparam logic [3:0] OP_HALT  = 4'hA;

  localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

  state_t                 state_q, state_d;
  logic [7:0]             wait_q, wait_d;
  logic                   berr_q, berr_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   retire;

  logic fetch_go;
  logic is_alu;
  logic is_ld;
  logic is_st;
  logic is_mem;
  logic is_jmp;
  logic is_hlt;
  logic in_rst;

`ifdef STEP_MODE_EN
  assign fetch_go = Step;
`else
  assign fetch_go = 1'b1;
`endif

  assign in_rst = ~Reset_n;

  // Opcode class flags; IR is stable from DECODE onward.
  assign is_alu = (bus.Opcode == OP_ALU);
  assign is_ld  = (bus.Opcode == OP_LOAD);
  assign is_st  = (bus.Opcode == OP_STORE);
  assign is_mem = is_ld | is_st;
  assign is_jmp = (bus.Opcode == OP_BEQZ) |
                  (bus.Opcode == OP_BNEZ) |
                  (bus.Opcode == OP_J)    |
                  (bus.Opcode == OP_JR)   |
                  (bus.Opcode == OP_JAL);
  assign is_hlt = (bus.Opcode == OP_HALT);

  // Next-state, wait counter and bus-error logic.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    berr_d  = berr_q;
    retire  = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (fetch_go) begin
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        unique case (1'b1)
          is_alu: state_d = S_EXEC;
          is_mem: state_d = S_MEM;
          is_jmp: state_d = S_JUMP;
          is_hlt: state_d = S_HALT;
          default: begin
            // Illegal opcode retires as a NOP.
            state_d = S_FETCH;
            retire  = 1'b1;
          end
        endcase
      end
      S_EXEC: begin
        state_d = S_WB;
      end
      S_MEM: begin
        if (bus.MemReady) begin
          wait_d = '0;
          if (is_ld) begin
            state_d = S_WB;
          end else begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end
        end else if (wait_q + 8'd1 == TMO) begin
          // Timed-out access is abandoned, not retired.
          wait_d  = '0;
          berr_d  = 1'b1;
          state_d = S_FETCH;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_WB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_JUMP: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Saturating retired-instruction counter.
  always_comb begin
    cnt_d = cnt_q;
    if (retire && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      berr_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      berr_q  <= berr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output decode from the registered state.
  logic [1:0] pc_sel;
  logic       pc_wr;
  logic       ir_wr;
  logic       acc_wr;
  logic       acc_src;
  logic       mem_rd;
  logic       mem_wr;
  logic       link_wr;
  logic       halted;

  always_comb begin
    pc_sel  = 2'd0;
    pc_wr   = 1'b0;
    ir_wr   = 1'b0;
    acc_wr  = 1'b0;
    acc_src = 1'b0;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    link_wr = 1'b0;
    halted  = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (fetch_go) begin
          ir_wr = 1'b1;
          pc_wr = 1'b1;
        end
      end
      S_MEM: begin
        mem_rd = is_ld;
        mem_wr = is_st;
      end
      S_WB: begin
        acc_wr  = 1'b1;
        acc_src = is_ld;
      end
      S_JUMP: begin
        case (bus.Opcode)
          OP_BEQZ: begin
            pc_sel = 2'd1;
            pc_wr  = bus.Zero;
          end
          OP_BNEZ: begin
            pc_sel = 2'd1;
            pc_wr  = ~bus.Zero;
          end
          OP_J: begin
            pc_sel = 2'd3;
            pc_wr  = 1'b1;
          end
          OP_JR: begin
            pc_sel = 2'd2;
            pc_wr  = 1'b1;
          end
          OP_JAL: begin
            pc_sel  = 2'd3;
            pc_wr   = 1'b1;
            link_wr = 1'b1;
          end
          default: begin
            pc_sel = 2'd0;
          end
        endcase
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        halted = 1'b0;
      end
    endcase
  end

  // Held reset forces every output quiet, even in FETCH.
  assign bus.PCSelect   = in_rst ? 2'd0 : pc_sel;
  assign bus.PCWrite    = pc_wr   & ~in_rst;
  assign bus.IRWrite    = ir_wr   & ~in_rst;
  assign bus.AccWrite   = acc_wr  & ~in_rst;
  assign bus.AccSrcMem  = acc_src & ~in_rst;
  assign bus.MemRead    = mem_rd  & ~in_rst;
  assign bus.MemWrite   = mem_wr  & ~in_rst;
  assign bus.LinkWrite  = link_wr & ~in_rst;
  assign bus.Halted     = halted  & ~in_rst;
  assign bus.BusErr     = berr_q  & ~in_rst;
  assign bus.State      = in_rst ? 3'd0 : state_q;
  assign bus.InstrCount = in_rst ? '0 : cnt_q;

endmodule
